// File: rtl/fir_pkg.sv
// fir_pkg: FSM encoding, accumulator sizing and the round/saturate helper
// shared by the multi-channel FIR top and its per-channel lanes.
package fir_pkg;
    localparam logic [1:0] S_IN = 2'd0, S_MAC = 2'd1, S_RND = 2'd2, S_OUT = 2'd3;

    typedef struct packed {
        logic               sat;
        logic signed [63:0] y;
    } rs_t;

    function automatic int accw(input int dw, input int cw, input int ns);
        return dw + cw + $clog2(ns);
    endfunction

    // Round half up, then clip to the signed dw-bit range and flag the clip.
    function automatic rs_t rnd_sat(input logic signed [63:0] a, input int sh, input int dw);
        logic signed [63:0] r, hi, lo;
        rs_t o;
        r = sh > 0 ? (a + (64'sd1 <<< (sh - 1))) >>> sh : a;
        hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (dw - 1));
        o.sat = r > hi || r < lo;
        o.y = r > hi ? hi : r < lo ? lo : r;
        return o;
    endfunction
endpackage

// File: rtl/fir_mac_lane.sv
// fir_mac_lane: one channel's delay line, registered multiplier,
// accumulator and round/saturate output.
module fir_mac_lane
    import fir_pkg::*;
#(
    parameter int DWIDTH    = 16,
    parameter int CWIDTH    = 16,
    parameter int NR_STAGES = 32,
    parameter int SHIFT     = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         shift,
    input  logic                         clr,
    input  logic                         acc_en,
    input  logic                         tap_vld,
    input  logic [$clog2(NR_STAGES)-1:0] tap_idx,
    input  logic signed [CWIDTH-1:0]     coef,
    input  logic signed [DWIDTH-1:0]     x_in,
    output logic signed [DWIDTH-1:0]     x_cur,
    output logic signed [DWIDTH-1:0]     y,
    output logic                         sat
);
    localparam int ACCW = accw(DWIDTH, CWIDTH, NR_STAGES);
    localparam int PW   = DWIDTH + CWIDTH;

    logic signed [DWIDTH-1:0] dl_q [NR_STAGES];
    logic signed [DWIDTH-1:0] dl_d [NR_STAGES];
    logic signed [PW-1:0]     mul, prod_q, prod_d;
    logic signed [ACCW-1:0]   acc_q, acc_d;
    rs_t                      rs;

    // The product is registered, so the accumulator trails the tap counter by one cycle.
    always_comb begin
        dl_d = dl_q;
        if (shift) begin
            dl_d[0] = x_in;
            for (int i = 1; i < NR_STAGES; i++) dl_d[i] = dl_q[i-1];
        end
        mul = dl_q[tap_idx] * coef;
        prod_d = (clr || !tap_vld) ? '0 : mul;
        acc_d = clr ? '0 : acc_en ? acc_q + ACCW'(prod_q) : acc_q;
        rs = rnd_sat(64'(acc_q), SHIFT, DWIDTH);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dl_q   <= '{default: '0};
            prod_q <= '0;
            acc_q  <= '0;
        end else begin
            dl_q   <= dl_d;
            prod_q <= prod_d;
            acc_q  <= acc_d;
        end
    end

    assign x_cur = dl_q[0];
    assign y     = DWIDTH'(rs.y);
    assign sat   = rs.sat;
endmodule

// File: rtl/fir_mc_seq.sv
// fir_mc_seq: time-multiplexed multi-channel FIR with 4-phase req/ack ports,
// registered coefficients, rounding, saturation and a bypass path.
module fir_mc_seq
    import fir_pkg::*;
#(
    parameter int NR_CH     = 2,
    parameter int NR_STAGES = 32,
    parameter int DWIDTH    = 16,
    parameter int CWIDTH    = 16,
    parameter int SHIFT     = 16,
    parameter int PWIDTH    = NR_CH * DWIDTH,
    parameter int HWIDTH    = NR_STAGES * CWIDTH
) (
    input  logic              clk,
    input  logic              rst,
    output logic              in_req,
    input  logic              in_ack,
    input  logic [0:PWIDTH-1] in_data,
    output logic              out_req,
    input  logic              out_ack,
    output logic [0:PWIDTH-1] out_data,
    input  logic [0:HWIDTH-1] h_in,
    input  logic              bypass,
    output logic              sat_flag
);
    localparam int KW = $clog2(NR_STAGES + 1);
    localparam int IW = $clog2(NR_STAGES);

    logic [1:0]              state_q, state_d;
    logic [KW-1:0]           k_q, k_d;
    logic                    in_req_q, in_req_d, out_req_q, out_req_d, sat_q, sat_d;
    logic [0:PWIDTH-1]       out_q, out_d, y_all, x_all;
    logic [0:HWIDTH-1]       coef_q, coef_d;
    logic [NR_CH-1:0]        sat_v;
    logic                    cap, tap_vld;
    logic signed [CWIDTH-1:0] coef_k;

    assign cap     = state_q == S_IN && in_req_q && in_ack;
    assign tap_vld = state_q == S_MAC && k_q < KW'(NR_STAGES);
    assign coef_k  = coef_q[k_q[IW-1:0] * CWIDTH +: CWIDTH];

    for (genvar c = 0; c < NR_CH; c++) begin : g_lane
        fir_mac_lane #(
            .DWIDTH(DWIDTH), .CWIDTH(CWIDTH), .NR_STAGES(NR_STAGES), .SHIFT(SHIFT)
        ) u_lane (
            .clk    (clk),
            .rst    (rst),
            .shift  (cap),
            .clr    (cap),
            .acc_en (state_q == S_MAC),
            .tap_vld(tap_vld),
            .tap_idx(k_q[IW-1:0]),
            .coef   (coef_k),
            .x_in   (in_data[c*DWIDTH +: DWIDTH]),
            .x_cur  (x_all[c*DWIDTH +: DWIDTH]),
            .y      (y_all[c*DWIDTH +: DWIDTH]),
            .sat    (sat_v[c])
        );
    end

    // The MAC phase runs one extra cycle (k == NR_STAGES) to drain the product register.
    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        in_req_d  = 1'b0;
        out_req_d = out_req_q;
        out_d     = out_q;
        sat_d     = sat_q;
        coef_d    = coef_q;
        case (state_q)
            S_IN: begin
                in_req_d = !in_ack;
                if (cap) begin
                    coef_d  = h_in;
                    k_d     = '0;
                    state_d = bypass ? S_OUT : S_MAC;
                end
            end
            S_MAC: begin
                k_d = k_q + 1'b1;
                if (k_q == KW'(NR_STAGES)) state_d = S_RND;
            end
            S_RND: if (!out_ack) begin
                out_d     = y_all;
                sat_d     = |sat_v;
                out_req_d = 1'b1;
                state_d   = S_OUT;
            end
            default: begin
                if (!out_req_q && !out_ack) begin
                    out_d     = x_all;
                    sat_d     = 1'b0;
                    out_req_d = 1'b1;
                end else if (out_req_q && out_ack) begin
                    out_req_d = 1'b0;
                    state_d   = S_IN;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IN;
            k_q       <= '0;
            in_req_q  <= 1'b0;
            out_req_q <= 1'b0;
            out_q     <= '0;
            sat_q     <= 1'b0;
            coef_q    <= '0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            in_req_q  <= in_req_d;
            out_req_q <= out_req_d;
            out_q     <= out_d;
            sat_q     <= sat_d;
            coef_q    <= coef_d;
        end
    end

    assign in_req   = in_req_q;
    assign out_req  = out_req_q;
    assign out_data = out_q;
    assign sat_flag = sat_q;
endmodule

// File: tb/tb_fir_mc_seq.sv
// tb_fir_mc_seq: randomized and directed stimulus for fir_mc_seq, checked on
// every output transfer against a direct-form convolution model.
module tb_fir_mc_seq;
    localparam int NCH = 2, NS = 32, DW = 16, CW = 16, PW = NCH * DW, HW = NS * CW;

    logic          clk = 1'b0, rst = 1'b1;
    logic          in_req, in_ack = 1'b0, out_req, out_ack = 1'b0, bypass = 1'b0, sat_flag;
    logic [0:PW-1] in_data = '0, out_data;
    logic [0:HW-1] h_in = '0;

    always #5 clk = ~clk;

    fir_mc_seq dut (
        .clk(clk), .rst(rst), .in_req(in_req), .in_ack(in_ack), .in_data(in_data),
        .out_req(out_req), .out_ack(out_ack), .out_data(out_data),
        .h_in(h_in), .bypass(bypass), .sat_flag(sat_flag)
    );

    typedef struct {
        logic [31:0] d;
        logic        s;
        int          lat;
        bit          lit;
        logic [31:0] ld;
        logic        ls;
        bit          neg;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        m_e;
    int          checks = 0, errors = 0, cyc = 0, cap_cyc = 0, n_sent = 0, n_out = 0, lazy_out = 0;
    int          h[NS];
    longint      hist[NCH][NS];
    int          y0, y1;
    logic        p_in_req = 0, p_in_ack = 0, p_out_req = 0, p_out_ack = 0, p_sat = 0;
    logic [31:0] p_out = '0;

    task automatic chk(input string n, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", n, got, want);
        end
    endtask

    task automatic die(input string n);
        checks++;
        errors++;
        $display("FAIL %s: timed out", n);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    endtask

    function automatic logic [0:HW-1] pack_h();
        logic [0:HW-1] v;
        for (int k = 0; k < NS; k++) v[k*CW +: CW] = h[k][15:0];
        return v;
    endfunction

    // Model: y_c = clip(round(sum_k x_c[n-k]*h[k] / 2^16)); bypass echoes the sample.
    task automatic send(input logic [31:0] d, input logic byp, input int lazy_in,
                        input bit lit, input logic [31:0] ld, input logic ls, input bit neg);
        exp_t   e;
        longint acc, r;
        int     t = 0;
        while (!in_req && t < 300) begin @(negedge clk); t++; end
        if (!in_req) die("in_req_wait");
        @(posedge clk); #1;
        for (int c = 0; c < NCH; c++) begin
            for (int k = NS - 1; k > 0; k--) hist[c][k] = hist[c][k-1];
            hist[c][0] = longint'($signed(d[31-16*c -: 16]));
        end
        e.d = byp ? d : '0;
        e.s = 1'b0;
        if (!byp) begin
            for (int c = 0; c < NCH; c++) begin
                acc = 0;
                for (int k = 0; k < NS; k++) acc += hist[c][k] * h[k];
                r = (acc + 32768) >>> 16;
                if (r > 32767) begin r = 32767; e.s = 1'b1; end
                else if (r < -32768) begin r = -32768; e.s = 1'b1; end
                e.d[31-16*c -: 16] = r[15:0];
            end
        end
        e.lat = byp ? (lazy_out == 0 ? 1 : -1) : NS + 2;
        e.lit = lit;
        e.ld  = ld;
        e.ls  = ls;
        e.neg = neg;
        exp_q.push_back(e);
        in_data = d;
        bypass  = byp;
        h_in    = pack_h();
        in_ack  = 1'b1;
        n_sent++;
        t = 0;
        do begin @(negedge clk); t++; end while (in_req && t < 50);
        if (in_req) die("in_req_drop");
        @(posedge clk); #1;
        h_in   = {HW/32{$urandom}};
        bypass = 1'($urandom);
        repeat (lazy_in) @(posedge clk);
        #1 in_ack = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1 rst = 1'b1;
        #2;
        chk("rst_in_req", 64'(in_req), 0);
        chk("rst_out_req", 64'(out_req), 0);
        chk("rst_out_data", 64'(out_data), 0);
        chk("rst_sat_flag", 64'(sat_flag), 0);
        n_sent -= exp_q.size();
        exp_q.delete();
        for (int c = 0; c < NCH; c++) for (int k = 0; k < NS; k++) hist[c][k] = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic wait_drain();
        int t = 0;
        while (exp_q.size() > 0 && t < 300) begin @(negedge clk); t++; end
        chk("drain", 64'(exp_q.size()), 0);
        repeat (8) @(posedge clk);
    endtask

    task automatic run_impulse();
        for (int k = 0; k < NS; k++) h[k] = k * 256;
        for (int n = 0; n <= NS; n++)
            send(n == 0 ? 32'h40000000 : 32'h0, 1'b0, 0, 1'b1,
                 {16'(n < NS ? 64 * n : 0), 16'h0}, 1'b0, 1'b0);
        wait_drain();
    endtask

    always @(posedge clk) cyc++;

    initial begin
        forever begin
            @(negedge clk);
            if (out_req && !rst) begin
                @(posedge clk); #1 out_ack = 1'b1;
                do @(negedge clk); while (out_req && !rst);
                repeat (lazy_out) @(posedge clk);
                @(posedge clk); #1 out_ack = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            p_in_req = 0; p_in_ack = 0; p_out_req = 0; p_out_ack = 0;
        end else begin
            if (in_req && !p_in_req) chk("in_req_rise_ack_low", 64'(p_in_ack), 0);
            if (p_in_req && !in_req) cap_cyc = cyc;
            if (out_req && !p_out_req) begin
                chk("out_req_rise_ack_low", 64'(p_out_ack), 0);
                chk("out_expected", 64'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    m_e = exp_q.pop_front();
                    n_out++;
                    chk("out_data", 64'(out_data), 64'(m_e.d));
                    chk("sat_flag", 64'(sat_flag), 64'(m_e.s));
                    if (m_e.lat >= 0) chk("latency", 64'(cyc - cap_cyc), 64'(m_e.lat));
                    if (m_e.lit) begin
                        chk("lit_data", 64'(out_data), 64'(m_e.ld));
                        chk("lit_sat", 64'(sat_flag), 64'(m_e.ls));
                    end
                    if (m_e.neg) begin
                        y0 = $signed(out_data[0:15]);
                        y1 = $signed(out_data[16:31]);
                        chk("neg_symmetry", 64'(y0 + y1 >= -1 && y0 + y1 <= 1), 1);
                    end
                end
            end else if (out_req) begin
                chk("hold_data", 64'(out_data), 64'(p_out));
                chk("hold_sat", 64'(sat_flag), 64'(p_sat));
            end
            p_in_req = in_req; p_in_ack = in_ack; p_out_req = out_req; p_out_ack = out_ack;
            p_out = out_data; p_sat = sat_flag;
        end
    end

    initial begin
        int a;
        do_reset();
        run_impulse();
        for (int k = 0; k < NS; k++) h[k] = 32'h7FFF;
        for (int n = 0; n < NS; n++) send(32'h7FFF7FFF, 1'b0, 0, n == NS - 1, 32'h7FFF7FFF, 1'b1, 1'b0);
        for (int n = 0; n < NS; n++) send(32'h80008000, 1'b0, 0, n == NS - 1, 32'h80008000, 1'b1, 1'b0);
        wait_drain();
        send(32'h1234ABCD, 1'b1, 0, 1'b1, 32'h1234ABCD, 1'b0, 1'b0);
        wait_drain();
        lazy_out = 5;
        for (int n = 0; n < 6; n++) send($urandom, 1'(n % 2), 5, 1'b0, '0, 1'b0, 1'b0);
        wait_drain();
        lazy_out = 0;
        for (int k = 0; k < NS; k++) h[k] = 256;
        send(32'h40000000, 1'b0, 0, 1'b0, '0, 1'b0, 1'b0);
        repeat (10) @(posedge clk);
        do_reset();
        run_impulse();
        for (int k = 0; k < NS; k++) h[k] = (k < NS / 2 ? k + 1 : NS - k) * 240;
        for (int n = 0; n < 40; n++) begin
            a = int'($urandom_range(65534)) - 32767;
            send({16'(a), 16'(-a)}, 1'b0, int'($urandom_range(2)), 1'b0, '0, 1'b0, 1'b1);
        end
        wait_drain();
        chk("sample_output_count", 64'(n_out), 64'(n_sent));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
